// File: rtl/matdet_seq_pkg.sv
// Shared types and constants for the sequential determinant engine.
// Product-index tables map each minor product step to the flat element indices it reads.
package matdet_seq_pkg;

    typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;

    localparam int L2 = 3;
    localparam int L3 = 9;

    // Entry [s] is the element index (r*N+c) of each multiplicand at product step s; unused slots are 0.
    localparam logic [7:0][3:0] PA2 = {24'd0, 4'd1, 4'd0};
    localparam logic [7:0][3:0] PB2 = {24'd0, 4'd2, 4'd3};
    localparam logic [7:0][3:0] PA3 = {8'd0, 4'd4, 4'd3, 4'd5, 4'd3, 4'd5, 4'd4};
    localparam logic [7:0][3:0] PB3 = {8'd0, 4'd6, 4'd7, 4'd6, 4'd8, 4'd7, 4'd8};

endpackage

// File: rtl/matdet_seq_mul.sv
// Fixed-point signed multiply: full product, arithmetic shift by BIN_POS, truncate.
module matdet_seq_mul #(
    parameter int DATA_WIDTH = 16,
    parameter int BIN_POS    = 8
) (
    input  logic signed [DATA_WIDTH-1:0] x,
    input  logic signed [DATA_WIDTH-1:0] y,
    output logic signed [DATA_WIDTH-1:0] p
);
    logic signed [2*DATA_WIDTH-1:0] full;

    assign full = x * y;
    assign p    = DATA_WIDTH'(full >>> BIN_POS);
endmodule

// File: rtl/matdet_seq_sub.sv
// Wrapping two's-complement subtract.
module matdet_seq_sub #(
    parameter int DATA_WIDTH = 16
) (
    input  logic signed [DATA_WIDTH-1:0] x,
    input  logic signed [DATA_WIDTH-1:0] y,
    output logic signed [DATA_WIDTH-1:0] d
);
    assign d = x - y;
endmodule

// File: rtl/matdet_seq.sv
// Sequential 2x2 / 3x3 fixed-point determinant, one product per cycle through a shared multiplier.
// Cofactor expansion along row 0: minor products first, then three multiply-accumulates.
module matdet_seq
    import matdet_seq_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int BIN_POS     = 8,
    parameter int MATRIX_SIZE = 3
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          start,
    input  logic [DATA_WIDTH*MATRIX_SIZE*MATRIX_SIZE-1:0] a,
    output logic                                          busy,
    output logic                                          done,
    output logic [DATA_WIDTH-1:0]                         det
);
    localparam int NE = MATRIX_SIZE * MATRIX_SIZE;
    localparam int NP = (MATRIX_SIZE == 2) ? 2 : 6;
    localparam int NA = (MATRIX_SIZE == 2) ? 1 : 3;
    localparam logic [7:0][3:0] PA = (MATRIX_SIZE == 2) ? PA2 : PA3;
    localparam logic [7:0][3:0] PB = (MATRIX_SIZE == 2) ? PB2 : PB3;

    if (MATRIX_SIZE != 2 && MATRIX_SIZE != 3) begin : g_bad_size
        $error("matdet_seq: MATRIX_SIZE must be 2 or 3");
    end

    typedef logic signed [DATA_WIDTH-1:0] elem_t;

    state_t                   state, state_nx;
    logic [3:0]               step, step_nx;
    logic                     take;
    logic [NE*DATA_WIDTH-1:0] m, src;
    elem_t                    p [6];
    elem_t                    acc, mx, my, prod, sx, sy, diff;
    logic [2:0]               mstep;

    function automatic elem_t el(input logic [NE*DATA_WIDTH-1:0] v, input logic [3:0] i);
        return elem_t'(v[i*DATA_WIDTH +: DATA_WIDTH]);
    endfunction

    always_comb begin
        state_nx = state;
        step_nx  = step;
        take     = 1'b0;
        case (state)
            IDLE: if (start) begin
                take     = 1'b1;
                state_nx = MUL;
                step_nx  = 4'd0;
            end
            MUL: if (step == 4'(NP - 1)) begin
                state_nx = ACC;
                step_nx  = 4'd0;
            end else step_nx = step + 4'd1;
            ACC: if (step == 4'(NA - 1)) begin
                state_nx = DONE;
                step_nx  = 4'd0;
            end else step_nx = step + 4'd1;
            // A restart from DONE folds the first product into the accept edge, keeping period L.
            DONE: if (start) begin
                take     = 1'b1;
                state_nx = MUL;
                step_nx  = 4'd1;
            end else state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        sx = p[0];
        sy = p[1];
        if (step == 4'd1) begin
            sx = p[2];
            sy = p[3];
        end else if (step == 4'd2) begin
            sx = p[4];
            sy = p[5];
        end
    end

    always_comb begin
        src   = (state == DONE) ? a : m;
        mstep = (state == DONE) ? 3'd0 : step[2:0];
        mx    = el(src, PA[mstep]);
        my    = el(src, PB[mstep]);
        if (state == ACC) begin
            mx = el(m, step);
            my = diff;
        end
    end

    matdet_seq_mul #(.DATA_WIDTH(DATA_WIDTH), .BIN_POS(BIN_POS)) u_mul (
        .x(mx), .y(my), .p(prod)
    );

    matdet_seq_sub #(.DATA_WIDTH(DATA_WIDTH)) u_sub (
        .x(sx), .y(sy), .d(diff)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            step  <= '0;
            m     <= '0;
            acc   <= '0;
            det   <= '0;
            for (int i = 0; i < 6; i++) p[i] <= '0;
        end else begin
            state <= state_nx;
            step  <= step_nx;
            if (take) m <= a;
            for (int i = 0; i < 6; i++)
                if ((state == MUL && step == 4'(i)) || (take && state == DONE && i == 0))
                    p[i] <= prod;
            if (state == ACC) begin
                if (MATRIX_SIZE == 2)   det <= diff;
                else if (step == 4'd0)  acc <= prod;
                else if (step == 4'd1)  acc <= acc - prod;
                else                    det <= acc + prod;
            end
        end
    end

    assign busy = (state == MUL) || (state == ACC);
    assign done = (state == DONE);

endmodule

// File: tb/tb_matdet_seq.sv
// Directed bench for matdet_seq: one 3x3 and one 2x2 instance sharing clock and reset.
module tb_matdet_seq;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start3 = 1'b0, start2 = 1'b0;
    logic [143:0] a3 = '0;
    logic [63:0]  a2 = '0;
    logic         busy3, done3, busy2, done2;
    logic [15:0]  det3, det2;
    int           errs = 0, checks = 0;

    always #5 clk = ~clk;

    matdet_seq #(.DATA_WIDTH(16), .BIN_POS(8), .MATRIX_SIZE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .a(a3),
        .busy(busy3), .done(done3), .det(det3)
    );

    matdet_seq #(.DATA_WIDTH(16), .BIN_POS(8), .MATRIX_SIZE(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2),
        .busy(busy2), .done(done2), .det(det2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [143:0] m3(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
        int v[9];
        logic [143:0] r;
        v = '{e0, e1, e2, e3, e4, e5, e6, e7, e8};
        r = '0;
        for (int i = 0; i < 9; i++) r[i*16 +: 16] = 16'(v[i] * 256);
        return r;
    endfunction

    function automatic logic [63:0] m2(input logic [15:0] e00, e01, e10, e11);
        return {e11, e10, e01, e00};
    endfunction

    task automatic go(input bit n2, input logic [143:0] mat, input logic [15:0] exp, input string tag);
        int n;
        bit bb;
        int lat;
        lat = n2 ? 3 : 9;
        @(negedge clk);
        if (n2) begin a2 = mat[63:0]; start2 = 1'b1; end
        else    begin a3 = mat;       start3 = 1'b1; end
        @(posedge clk); #1;
        start2 = 1'b0;
        start3 = 1'b0;
        n  = 0;
        bb = 1'b1;
        while (!(n2 ? done2 : done3) && n < 30) begin
            if (!(n2 ? busy2 : busy3)) bb = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " latency"}, n, lat);
        chk({tag, " busy in flight"}, bb, 1);
        chk({tag, " det"}, n2 ? det2 : det3, exp);
        chk({tag, " busy at done"}, n2 ? busy2 : busy3, 0);
        @(posedge clk); #1;
        chk({tag, " done one cycle"}, n2 ? done2 : done3, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd, first, chg;
        logic [15:0] dv, prevdet;
        int dcyc[3];
        logic [15:0] dval[3];

        #2;
        chk("reset busy3", busy3, 0);
        chk("reset done3", done3, 0);
        chk("reset det3",  det3,  0);
        chk("reset busy2", busy2, 0);
        chk("reset done2", done2, 0);
        chk("reset det2",  det2,  0);
        @(negedge clk);
        rst_n = 1'b1;

        go(0, m3(1,0,0, 0,1,0, 0,0,1), 16'h0100, "n3 identity");
        go(0, m3(2,0,1, 1,3,2, 1,1,1), 16'h0000, "n3 singular");
        go(0, m3(1,2,3, 0,1,4, 5,6,0), 16'h0100, "n3 m123");

        go(1, {80'd0, m2(16'h0200, 16'h0100, 16'h0100, 16'h0100)}, 16'h0100, "n2 [2 1;1 1]");
        go(1, {80'd0, m2(16'h0000, 16'h0100, 16'h0100, 16'h0000)}, 16'hFF00, "n2 swap");
        go(1, {80'd0, m2(16'h0080, 16'h0040, 16'h00C0, 16'h0180)}, 16'h0090, "n2 fraction");
        go(1, {80'd0, m2(16'hFFFF, 16'h0000, 16'h0000, 16'h0080)}, 16'hFFFF, "n2 floor shift");
        go(1, {80'd0, m2(16'h7F00, 16'h0000, 16'h0000, 16'h0200)}, 16'hFE00, "n2 wrap");

        // start pulse and operand change mid-run must not disturb the op in flight
        @(negedge clk);
        a3 = m3(2,0,0, 0,2,0, 0,0,2);
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        nd = 0; first = -1; dv = '0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 3) begin
                @(negedge clk);
                start3 = 1'b1;
                a3 = m3(2,0,1, 1,3,2, 1,1,1);
            end
            @(posedge clk); #1;
            if (c == 3) start3 = 1'b0;
            if (done3) begin
                nd++;
                if (first < 0) begin first = c; dv = det3; end
            end
        end
        chk("ignore start: done count", nd, 1);
        chk("ignore start: done cycle", first, 9);
        chk("ignore start: det", dv, 16'h0800);

        // held start: back-to-back every 9 cycles, operands scrambled between accepts
        @(negedge clk);
        a3 = m3(1,0,0, 0,1,0, 0,0,1);
        start3 = 1'b1;
        @(posedge clk); #1;
        nd = 0; chg = 0;
        dcyc = '{-1, -1, -1};
        dval = '{16'h0, 16'h0, 16'h0};
        prevdet = det3;
        for (int c = 1; c <= 27; c++) begin
            @(posedge clk); #1;
            if (done3) begin
                if (nd < 3) begin dcyc[nd] = c; dval[nd] = det3; end
                nd++;
                if (nd == 1) a3 = m3(2,0,1, 1,3,2, 1,1,1);
                if (nd == 2) a3 = m3(2,0,0, 0,2,0, 0,0,2);
                if (nd >= 3) start3 = 1'b0;
            end else begin
                if (det3 !== prevdet) chg++;
                a3 = 144'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
            end
            prevdet = det3;
        end
        start3 = 1'b0;
        chk("held start: done count", nd, 3);
        chk("held start: cycle 1", dcyc[0], 9);
        chk("held start: cycle 2", dcyc[1], 18);
        chk("held start: cycle 3", dcyc[2], 27);
        chk("held start: det 1", dval[0], 16'h0100);
        chk("held start: det 2", dval[1], 16'h0000);
        chk("held start: det 3", dval[2], 16'h0800);
        chk("held start: det stable between dones", chg, 0);

        // reset mid-operation aborts without a done pulse
        repeat (2) @(posedge clk);
        @(negedge clk);
        a3 = m3(1,2,3, 0,1,4, 5,6,0);
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre-reset busy", busy3, 1);
        rst_n = 1'b0;
        #1;
        chk("abort busy", busy3, 0);
        chk("abort done", done3, 0);
        chk("abort det", det3, 0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (done3 || busy3) nd++;
        end
        chk("abort no done or busy", nd, 0);
        go(0, m3(2,0,0, 0,2,0, 0,0,2), 16'h0800, "post reset");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
